// File: rtl/lockout_timer_pkg.sv
// lockout_timer_pkg: register offsets, CTRL/STATUS bit indices and FSM states shared by lockout_timer.
package lockout_timer_pkg;
    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_LOAD    = 8'h04;
    localparam logic [7:0] ADDR_REMAIN  = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h0C;
    localparam logic [7:0] ADDR_FAILCNT = 8'h10;
    localparam logic [7:0] ADDR_LAST    = ADDR_FAILCNT;
    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_FAIL    = 3;
    localparam int CTRL_FAILCLR = 4;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    typedef enum logic [1:0] {ST_IDLE, ST_COUNTING, ST_EXPIRED} state_t;
endpackage

// File: rtl/lockout_timer_if.sv
// lockout_timer_if: APB3 slave bus bundle for lockout_timer.
interface lockout_timer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/lockout_apb_regs.sv
// lockout_apb_regs: APB decode, LOAD/DONE registers, read mux and PSLVERR for lockout_timer.
module lockout_apb_regs
    import lockout_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    lockout_timer_if.slave   apb,
    input  logic [CNT_W-1:0] remain_i,
    input  logic             busy_i,
    input  logic             expire_i,
    input  logic [3:0]       failcnt_i,
    output logic [CNT_W-1:0] load_o,
    output logic             start_o,
    output logic             abort_o,
    output logic             fail_o,
    output logic             failclr_o
);
    logic [7:0]       addr;
    logic             access;
    logic             err;
    logic             wr;
    logic             rd;
    logic             wr_ctrl;
    logic             done_q;
    logic             done_d;
    logic [CNT_W-1:0] load_q;
    logic [CNT_W-1:0] load_d;
    logic             unused_ok;

    assign addr      = {apb.PADDR[7:2], 2'b00};
    assign access    = apb.PSEL & apb.PENABLE;
    assign err       = access & (addr > ADDR_LAST);
    assign wr        = access & apb.PWRITE & ~err;
    assign rd        = access & ~apb.PWRITE & ~err;
    assign wr_ctrl   = wr & (addr == ADDR_CTRL);
    assign unused_ok = ^{apb.PADDR[1:0], apb.PWDATA};

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = err;

    assign start_o   = wr_ctrl & apb.PWDATA[CTRL_START];
    assign abort_o   = wr_ctrl & apb.PWDATA[CTRL_ABORT];
    assign fail_o    = wr_ctrl & apb.PWDATA[CTRL_FAIL];
    assign failclr_o = wr_ctrl & apb.PWDATA[CTRL_FAILCLR];
    assign load_o    = load_q;

    assign load_d = (wr && addr == ADDR_LOAD) ? apb.PWDATA[CNT_W-1:0] : load_q;
    // expiry sets DONE even when a write-1-clear lands in the same cycle
    assign done_d = expire_i | (done_q & ~(wr && addr == ADDR_STATUS && apb.PWDATA[STAT_DONE]));

    assign apb.PRDATA = !rd                    ? '0 :
                        addr == ADDR_LOAD      ? 32'(load_q) :
                        addr == ADDR_REMAIN    ? 32'(remain_i) :
                        addr == ADDR_STATUS    ? 32'({done_q, busy_i}) :
                        addr == ADDR_FAILCNT   ? 32'(failcnt_i) : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            load_q <= '0;
            done_q <= 1'b0;
        end else begin
            load_q <= load_d;
            done_q <= done_d;
        end
    end
endmodule

// File: rtl/lockout_timer.sv
// lockout_timer: APB3 lockout countdown with TICK-driven REMAIN, LOCKED output and FABINT expiry pulse.
// Define LOCKOUT_TIMER_FAIL_CNT_EN to add the failed-attempt counter that auto-starts a lockout.
module lockout_timer
    import lockout_timer_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_FAILS = 3
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    lockout_timer_if.slave apb,
    input  logic           TICK,
    output logic           LOCKED,
    output logic           FABINT
);
    state_t           state_q;
    logic [CNT_W-1:0] remain_q;
    logic [CNT_W-1:0] load;
    logic [3:0]       failcnt;
    logic             start_w;
    logic             abort;
    logic             fail;
    logic             failclr;
    logic             auto_start;
    logic             start;
    logic             zero_load;
    logic             tick_cnt;
    logic             expire;

    lockout_apb_regs #(.CNT_W(CNT_W)) u_regs (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .apb       (apb),
        .remain_i  (remain_q),
        .busy_i    (LOCKED),
        .expire_i  (expire),
        .failcnt_i (failcnt),
        .load_o    (load),
        .start_o   (start_w),
        .abort_o   (abort),
        .fail_o    (fail),
        .failclr_o (failclr)
    );

`ifdef LOCKOUT_TIMER_FAIL_CNT_EN
    logic [3:0] failcnt_q;
    logic [3:0] fail_inc;
    logic       fail_ok;

    assign fail_ok    = fail & ~failclr & (state_q != ST_COUNTING);
    assign fail_inc   = (failcnt_q == 4'hF) ? 4'hF : failcnt_q + 4'd1;
    assign auto_start = fail_ok & (fail_inc == 4'(MAX_FAILS));
    assign failcnt    = failcnt_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) failcnt_q <= '0;
        else failcnt_q <= (failclr | auto_start) ? 4'd0 : fail_ok ? fail_inc : failcnt_q;
    end
`else
    logic unused_fail;

    assign unused_fail = fail ^ failclr ^ (MAX_FAILS != 0);
    assign auto_start  = 1'b0;
    assign failcnt     = 4'd0;
`endif

    // START beats a same-cycle TICK; ABORT beats both
    assign start     = start_w | auto_start;
    assign zero_load = (load == '0);
    assign tick_cnt  = (state_q == ST_COUNTING) & TICK;
    assign expire    = ~abort & (start ? zero_load : tick_cnt & (remain_q == CNT_W'(1)));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            LOCKED   <= 1'b0;
            FABINT   <= 1'b0;
        end else begin
            FABINT <= expire;
            if (abort) begin
                state_q <= ST_IDLE;
                LOCKED  <= 1'b0;
            end else if (start) begin
                state_q  <= zero_load ? ST_EXPIRED : ST_COUNTING;
                remain_q <= load;
                LOCKED   <= ~zero_load;
            end else if (tick_cnt) begin
                state_q  <= expire ? ST_EXPIRED : ST_COUNTING;
                remain_q <= remain_q - CNT_W'(1);
                LOCKED   <= ~expire;
            end else if (state_q == ST_EXPIRED) begin
                state_q <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_lockout_timer.sv
// tb_lockout_timer: directed APB/TICK vectors for lockout_timer with hand-computed expectations.
module tb_lockout_timer;
    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    logic TICK = 1'b0;
    logic LOCKED;
    logic FABINT;
    int   n_vec = 0;
    int   n_err = 0;
    int   fab_cnt = 0;
    int   fc;

    lockout_timer_if apb();

    lockout_timer #(.CNT_W(16), .MAX_FAILS(3)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (apb),
        .TICK    (TICK),
        .LOCKED  (LOCKED),
        .FABINT  (FABINT)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) if (FABINT) fab_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge PCLK);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic e);
        @(negedge PCLK);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = a;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        #1;
        d = apb.PRDATA;
        e = apb.PSLVERR;
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_rd(a, d, e);
        check(tag, d, exp);
    endtask

    task automatic tick_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(negedge PCLK);
            @(negedge PCLK);
            TICK = 1'b1;
            @(negedge PCLK);
            TICK = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
        repeat (3) @(negedge PCLK);
        check("rst_locked", LOCKED, 0);
        check("rst_fabint", FABINT, 0);
        check("rst_pready", apb.PREADY, 1);
        PRESETn = 1'b1;
        rd_chk("rst_remain", 8'h08, 0);
        rd_chk("rst_load", 8'h04, 0);
        rd_chk("rst_status", 8'h0C, 0);
        rd_chk("rst_failcnt", 8'h10, 0);

        // LOAD=3 countdown with ticks spaced 5 cycles apart
        fc = fab_cnt;
        apb_wr(8'h04, 32'd3);
        rd_chk("s1_load", 8'h04, 3);
        apb_wr(8'h00, 32'h1);
        check("s1_locked_start", LOCKED, 1);
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge PCLK);
            check("s1_locked_mid", LOCKED, 1);
            @(negedge PCLK);
            TICK = 1'b1;
            @(negedge PCLK);
            TICK = 1'b0;
        end
        check("s1_fabint", FABINT, 1);
        check("s1_unlocked", LOCKED, 0);
        @(negedge PCLK);
        check("s1_fabint_pulse", FABINT, 0);
        check("s1_fab_once", fab_cnt - fc, 1);
        rd_chk("s1_remain", 8'h08, 0);
        rd_chk("s1_done", 8'h0C, 32'h2);
        apb_wr(8'h0C, 32'h2);
        rd_chk("s1_done_clr", 8'h0C, 0);

        // LOAD=0 expires immediately
        apb_wr(8'h04, 32'd0);
        apb_wr(8'h00, 32'h1);
        check("s2_fabint", FABINT, 1);
        check("s2_locked", LOCKED, 0);
        @(negedge PCLK);
        check("s2_fabint_pulse", FABINT, 0);
        rd_chk("s2_done", 8'h0C, 32'h2);
        apb_wr(8'h0C, 32'h2);

        // ABORT keeps REMAIN, no interrupt; START+ABORT together stays idle
        fc = fab_cnt;
        apb_wr(8'h04, 32'd5);
        apb_wr(8'h00, 32'h1);
        tick_n(2, 2);
        apb_wr(8'h00, 32'h2);
        check("s3_abort_locked", LOCKED, 0);
        rd_chk("s3_remain", 8'h08, 3);
        apb_wr(8'h00, 32'h3);
        check("s3_startabort", LOCKED, 0);
        rd_chk("s3_status", 8'h0C, 0);
        rd_chk("s3_remain_kept", 8'h08, 3);
        check("s3_no_fab", fab_cnt - fc, 0);

        // restart reloads REMAIN; LOAD written mid-count waits for the next START
        apb_wr(8'h04, 32'd4);
        apb_wr(8'h00, 32'h1);
        tick_n(2, 1);
        rd_chk("s4_remain_2", 8'h08, 2);
        fc = fab_cnt;
        apb_wr(8'h00, 32'h1);
        rd_chk("s4_reload", 8'h08, 4);
        apb_wr(8'h04, 32'd7);
        rd_chk("s4_remain_keep", 8'h08, 4);
        tick_n(3, 1);
        check("s4_still_locked", LOCKED, 1);
        check("s4_no_fab", fab_cnt - fc, 0);
        tick_n(1, 1);
        check("s4_fabint", FABINT, 1);
        rd_chk("s4_load_new", 8'h04, 7);
        apb_wr(8'h0C, 32'h2);

        // unmapped access and reset mid-count
        apb_rd(8'h14, d, e);
        check("s5_err_data", d, 0);
        check("s5_err_flag", e, 1);
        apb_rd(8'h10, d, e);
        check("s5_ok_flag", e, 0);
        rd_chk("s5_ctrl_rd", 8'h00, 0);
        apb_wr(8'h14, 32'h1);
        check("s5_err_wr_ignored", LOCKED, 0);
        apb_wr(8'h04, 32'd10);
        apb_wr(8'h00, 32'h1);
        check("s5_locked", LOCKED, 1);
        tick_n(1, 1);
        fc = fab_cnt;
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        check("s5_rst_locked", LOCKED, 0);
        check("s5_rst_fabint", FABINT, 0);
        check("s5_rst_pready", apb.PREADY, 1);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        check("s5_rst_nofab", fab_cnt - fc, 0);
        rd_chk("s5_rst_remain", 8'h08, 0);
        rd_chk("s5_rst_load", 8'h04, 0);

`ifdef LOCKOUT_TIMER_FAIL_CNT_EN
        // three failures auto-start a LOAD=2 lockout
        apb_wr(8'h04, 32'd2);
        apb_wr(8'h00, 32'h8);
        rd_chk("f_cnt1", 8'h10, 1);
        apb_wr(8'h00, 32'h8);
        rd_chk("f_cnt2", 8'h10, 2);
        check("f_not_locked", LOCKED, 0);
        apb_wr(8'h00, 32'h8);
        check("f_auto_locked", LOCKED, 1);
        rd_chk("f_cnt_clr", 8'h10, 0);
        apb_wr(8'h00, 32'h8);
        rd_chk("f_ignored", 8'h10, 0);
        rd_chk("f_remain", 8'h08, 2);
        tick_n(2, 1);
        check("f_fabint", FABINT, 1);
        apb_wr(8'h00, 32'h8);
        rd_chk("f_cnt_again", 8'h10, 1);
        apb_wr(8'h00, 32'h18);
        rd_chk("f_failclr_wins", 8'h10, 0);
`else
        apb_wr(8'h04, 32'd2);
        apb_wr(8'h00, 32'h8);
        rd_chk("f_off_cnt", 8'h10, 0);
        apb_wr(8'h00, 32'h8);
        apb_wr(8'h00, 32'h8);
        check("f_off_locked", LOCKED, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lockout_timer.md
LOCKOUT_TIMER -- requirements
Module: lockout_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the LOAD and REMAIN counters, in ticks.
REQ-002 SHALL have parameter MAX_FAILS, default 3: number of failed attempts that auto-starts a lockout (used only with the REQ-030 macro).
REQ-003 PCLK  in  1  sole clock; all logic on its rising edge.
REQ-004 PRESETn  in  1  reset; asynchronous, active-low.
REQ-005 PSEL, PENABLE, PWRITE  in  1 each  APB3 control signals.
REQ-006 PADDR  in  8  byte address; bits [1:0] ignored.
REQ-007 PWDATA  in  32  write data.
REQ-008 PRDATA  out  32  read data.
REQ-009 PREADY  out  1  tied to 1 (zero wait states).
REQ-010 PSLVERR  out  1  error response for an unmapped address.
REQ-011 TICK  in  1  one-PCLK pulse, one per millisecond, from the upstream hardware timer's FABINT.
REQ-012 LOCKED  out  1  high while a lockout is counting.
REQ-013 FABINT  out  1  one-PCLK expiry interrupt pulse.

Function
REQ-014 SHALL decode a write when PSEL&PENABLE&PWRITE and a read when PSEL&PENABLE&!PWRITE.
REQ-014 (cont.) Register map:
- 0x00 CTRL, WO: bit0 START, bit1 ABORT, bit3 FAIL, bit4 FAILCLR; self-clearing strobes.
- 0x04 LOAD, RW, CNT_W bits.
- 0x08 REMAIN, RO.
- 0x0C STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear).
- 0x10 FAILCNT, RO, 4 bits.
REQ-015 SHALL drive PRDATA combinationally during the access phase, zero-extend narrower fields, and return 0 for CTRL and unmapped addresses.
REQ-016 SHALL assert PSLVERR during the access phase for any address above 0x10 and ignore that access.
REQ-017 SHALL implement an FSM with states IDLE, COUNTING and EXPIRED.
REQ-018 START in IDLE or EXPIRED SHALL copy LOAD to REMAIN and enter COUNTING on the next edge; if LOAD==0, the FSM SHALL enter EXPIRED instead.
REQ-019 START in COUNTING SHALL reload REMAIN from LOAD (restart) with no interrupt.
REQ-020 In COUNTING, each TICK SHALL decrement REMAIN by 1; the tick that makes REMAIN 0 SHALL move the FSM to EXPIRED.
REQ-021 Entering EXPIRED SHALL pulse FABINT for exactly one cycle and set DONE; EXPIRED SHALL return to IDLE after one cycle unless START is present.
REQ-022 ABORT SHALL force IDLE and leave REMAIN unchanged, with no FABINT; ABORT SHALL win over START written in the same cycle.
REQ-023 A START write and a TICK in the same cycle: START SHALL win and the TICK is dropped.
REQ-024 LOAD writes during COUNTING SHALL affect only the next START.
REQ-025 LOCKED and BUSY SHALL equal (state==COUNTING), registered.
REQ-026 A DONE write-1-clear coinciding with expiry SHALL leave DONE=1.

Reset
REQ-027 PRESETn low SHALL immediately force: FSM IDLE; REMAIN=0; LOAD=0; DONE=0; FAILCNT=0; LOCKED=0; FABINT=0.
REQ-028 Reset asserted during COUNTING SHALL abandon the count with no FABINT.
REQ-029 PREADY SHALL be 1 during reset.

Configuration
REQ-030 Macro LOCKOUT_TIMER_FAIL_CNT_EN defined:
- FAIL in IDLE or EXPIRED increments FAILCNT, saturating at 15; FAIL is ignored in COUNTING.
- When the incremented value reaches MAX_FAILS, the block SHALL auto-START as in REQ-018 and clear FAILCNT.
- FAILCLR zeroes FAILCNT; FAILCLR wins over FAIL in the same write.
REQ-031 Macro undefined: FAIL/FAILCLR ignored, FAILCNT reads 0, and no failure-counter flops are present.

Structure
REQ-032 Shared package lockout_timer_pkg SHALL hold the register offsets, CTRL/STATUS bit indices and the FSM state enum.
REQ-033 SHALL contain one sub-module, lockout_apb_regs (APB decode, register file, PSLVERR); the FSM and counter stay in the top level.

Verification
REQ-034 Bench SHALL cover these scenarios:
- LOAD=3, START, 3 TICKs spaced 5 cycles -> LOCKED for the whole count; FABINT 1 cycle after the 3rd TICK; DONE=1; REMAIN=0.
- LOAD=0, START -> no LOCKED; FABINT next cycle.
- LOAD=5, START, 2 TICKs, ABORT -> IDLE, REMAIN=3, no FABINT; then START+ABORT in the same write -> stays IDLE.
- LOAD=4, START, 2 TICKs, START again -> REMAIN=4; expiry only after 4 more TICKs.
- Read 0x14 -> PSLVERR=1, PRDATA=0; PRESETn low mid-count -> all outputs 0 at once.
- With LOCKOUT_TIMER_FAIL_CNT_EN, MAX_FAILS=3, LOAD=2: 3 FAIL writes -> LOCKED; FAILCNT=0; FAIL during lock ignored; expiry after 2 TICKs.
